mem_lsu: RTL and testbench
==========================

# mem_lsu

Parametrised multi-cycle load/store unit for the MEM stage of the MIPS pipeline. It takes a decoded memory op from EX/MEM and drives a req/ack data-bus handshake. It aligns and sign- or zero-extends read data and replicates write data onto big-endian byte lanes. It reports address-error and bus-error exceptions, stalling the pipeline until each access retires.

## Interface
- DATA_W, 32, data-bus width; 32 or 64 only.
- ADDR_W, 32, address width.
- TIMEOUT, 255, cycles waiting for ack before bus error; ≥1, counter width $clog2(TIMEOUT+1).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  op_type_i/mem_addr_i/reg2_i valid this cycle.
- op_type_i  in  7  `Op_Lb/Lbu/Lh/Lhu/Lw/Sb/Sh/Sw`; others are non-memory.
- mem_addr_i  in  ADDR_W  effective address.
- reg2_i  in  32  store data.
- flush_i  in  1  pipeline flush; current access is discarded.
- stall_o  out  1  hold upstream stages.
- result_valid_o  out  1  one-cycle pulse, access retired.
- result_o  out  32  extended load data (0 for stores).
- excepttype_o  out  32  0, 32'h4 (AdEL), 32'h5 (AdES), 32'h7 (DBE); qualified by result_valid_o.
- bus_req_o  out  1  request, held until ack.
- bus_we_o  out  1  write.
- bus_addr_o  out  ADDR_W  word-aligned address (low $clog2(DATA_W/8) bits 0).
- bus_sel_o  out  DATA_W/8  byte enables; MSB = lowest address.
- bus_wdata_o  out  DATA_W  lane-replicated store data.
- bus_ack_i  in  1  completes request; rdata valid same cycle.
- bus_rdata_i  in  DATA_W  read data.

## Operation
- States: IDLE, REQ, DRAIN, DONE.
- IDLE: on valid_i & memory op & !flush_i:
  - Misaligned (half: addr[0]≠0; word: addr[1:0]≠0): no bus cycle. Go DONE with AdEL for loads, AdES for stores.
  - Aligned: register addr, sel, wdata, op. Go REQ.
  - Non-memory op: stay IDLE; stall_o=0.
- REQ: bus_req_o=1; all bus outputs stable.
  - bus_ack_i: capture extended data. Go DONE.
  - Counter reaches TIMEOUT with no ack: drop req. Go DONE with DBE.
  - flush_i without ack: go DRAIN; request stays asserted.
  - flush_i with ack in the same cycle: go IDLE and discard.
- DRAIN: keep req until ack, then go IDLE with no result_valid_o. Timeout also returns to IDLE.
- DONE: result_valid_o=1 for one cycle. Go IDLE. flush_i in DONE suppresses result_valid_o.
- Lanes: N=DATA_W/8, lane index k=addr mod N. Byte sel bit (N-1-k). Half occupies bits (N-1-k) and (N-2-k). Word occupies 4 lanes at (addr mod N) aligned to 4.
- Store data replication: Sb copies reg2_i[7:0] to all lanes; Sh copies reg2_i[15:0]; Sw copies reg2_i[31:0] (twice at 64-bit).
- Load extension: Lb/Lh sign-extend from the lane MSB; Lbu/Lhu zero-extend.
- Stores: bus_we_o=1, result_o=0.
- stall_o=1:
  - combinationally in IDLE when a memory op is accepted;
  - throughout REQ and DRAIN;
  - 0 in DONE.
- A new op is accepted only in IDLE.

## Timing
- Reset values: state IDLE, counter 0, all outputs 0.
- rst mid-access drops bus_req_o immediately. The bus must tolerate an abandoned request.
- Latency from accept to result_valid_o:
  - misaligned: 1 cycle;
  - aligned: (ack cycle + 1).
- Zero-wait ack means ack in the first REQ cycle, so result_valid_o comes 2 cycles after accept.
- Counter resets on entry to REQ/DRAIN. Timeout fires on the cycle the count equals TIMEOUT.
- Ack and timeout in the same cycle: ack wins.

## Structure
- Shared defines/package:
  - op-type codes (existing `Op_*`);
  - exception codes 4/5/7;
  - state encoding.
- One combinational sub-module, `lsu_lane_align`, parametrised by DATA_W. It produces sel and wdata from (op, addr, reg2), and the extended result from (op, addr, rdata).
- The FSM, counter and registers live in `mem_lsu`.

## Test plan
- DATA_W=32, Lb addr 0x1003, rdata 0x112233F0, ack after 3 cycles:
  - during REQ: sel 0001, addr 0x1000;
  - result_o 0xFFFFFFF0, result_valid_o 5 cycles after accept.
- DATA_W=64, Sh addr 0x2006, reg2 0x0000ABCD:
  - sel 0x03, wdata 0xABCDABCDABCDABCD, we=1;
  - zero-wait ack: valid 2 cycles after accept.
- Lw addr 0x3002: no bus_req_o; next cycle result_valid_o with excepttype 0x4. Sw addr 0x3001: excepttype 0x5.
- TIMEOUT=4, no ack: req held 4 cycles, then excepttype 0x7; ack arriving later is ignored while IDLE.
- flush_i in 2nd REQ cycle, ack 2 cycles later: req held until ack, no result_valid_o, next op accepted the cycle after.
- rst asserted in REQ: next cycle all outputs 0, state IDLE; a Lhu at 0x10 with rdata 0x8001xxxx then returns 0x00008001.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: memory op codes, exception codes, FSM states and op decode helpers for the load/store unit
package mem_lsu_pkg;
  localparam logic [6:0] Op_Lb = 7'h20, Op_Lh = 7'h21, Op_Lw = 7'h23, Op_Lbu = 7'h24,
                         Op_Lhu = 7'h25, Op_Sb = 7'h28, Op_Sh = 7'h29, Op_Sw = 7'h2b;
  localparam logic [31:0] Exc_None = 32'h0, Exc_Adel = 32'h4, Exc_Ades = 32'h5, Exc_Dbe = 32'h7;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
  function automatic logic [2:0] op_size(input logic [6:0] op);
    return (op == Op_Lb || op == Op_Lbu || op == Op_Sb) ? 3'd1 :
           (op == Op_Lh || op == Op_Lhu || op == Op_Sh) ? 3'd2 :
           (op == Op_Lw || op == Op_Sw) ? 3'd4 : 3'd0;
  endfunction
  function automatic logic is_store(input logic [6:0] op);
    return op == Op_Sb || op == Op_Sh || op == Op_Sw;
  endfunction
  function automatic logic misaligned(input logic [6:0] op, input logic [1:0] a);
    return op_size(op) == 3'd2 ? a[0] : op_size(op) == 3'd4 ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data bus; master drives req/we/addr/sel/wdata, slave drives ack/rdata
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                req;
  logic                we;
  logic                ack;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W/8-1:0] sel;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  modport master(output req, we, addr, sel, wdata, input ack, rdata);
  modport slave(input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu_lane_align.sv
// lsu_lane_align: big-endian lane steering; op/lane k/reg2/rdata in, byte enables, replicated wdata and extended load result out
module lsu_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [6:0]                   op,
  input  logic [$clog2(DATA_W/8)-1:0]  k,
  input  logic [31:0]                  reg2,
  input  logic [DATA_W-1:0]            rdata,
  output logic [DATA_W/8-1:0]          sel,
  output logic [DATA_W-1:0]            wdata,
  output logic [31:0]                  result
);
  localparam int N = DATA_W / 8;
  logic [2:0] sz;
  logic [3:0] sb;
  logic [DATA_W-1:0] d;
  logic sx;
  always_comb begin
    sz = op_size(op);
    sb = 4'(N - int'(sz) - int'(k));
    sel = (sz == 3'd1 ? N'(1) : sz == 3'd2 ? N'(3) : sz == 3'd4 ? N'(15) : '0) << sb;
    wdata = sz == 3'd1 ? {N{reg2[7:0]}} : sz == 3'd2 ? {(N/2){reg2[15:0]}} : {(N/4){reg2}};
    d = rdata >> {sb, 3'b000};
    sx = op == Op_Lb || op == Op_Lh;
    result = sz == 3'd1 ? {{24{sx & d[7]}}, d[7:0]} :
             sz == 3'd2 ? {{16{sx & d[15]}}, d[15:0]} : d[31:0];
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store FSM; valid/op/addr/reg2/flush in, stall/result_valid/result/excepttype out, bus via mem_lsu_if.master
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [6:0]        op_type_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [31:0]       result_o,
  output logic [31:0]       excepttype_o,
  mem_lsu_if.master         bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(DATA_W / 8);
  state_t state;
  logic [CW-1:0] cnt;
  logic [6:0] op_q;
  logic [LW-1:0] k_q;
  logic [DATA_W/8-1:0] sel_c;
  logic [DATA_W-1:0] wdata_c;
  logic [31:0] res_c;
  logic accept, tmo;
  assign accept = state == IDLE && valid_i && !flush_i && op_size(op_type_i) != 3'd0;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign stall_o = accept || state == REQ || state == DRAIN;
  assign result_valid_o = state == DONE && !flush_i;
  assign bus.req = state == REQ || state == DRAIN;
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op     (state == IDLE ? op_type_i : op_q),
    .k      (state == IDLE ? mem_addr_i[LW-1:0] : k_q),
    .reg2   (reg2_i),
    .rdata  (bus.rdata),
    .sel    (sel_c),
    .wdata  (wdata_c),
    .result (res_c)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      k_q <= '0;
      bus.we <= 1'b0;
      bus.addr <= '0;
      bus.sel <= '0;
      bus.wdata <= '0;
      result_o <= '0;
      excepttype_o <= '0;
    end else begin
      cnt <= (state == REQ || state == DRAIN) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: if (accept) begin
          op_q <= op_type_i;
          k_q <= mem_addr_i[LW-1:0];
          result_o <= '0;
          if (misaligned(op_type_i, mem_addr_i[1:0])) begin
            state <= DONE;
            excepttype_o <= is_store(op_type_i) ? Exc_Ades : Exc_Adel;
          end else begin
            state <= REQ;
            excepttype_o <= Exc_None;
            bus.we <= is_store(op_type_i);
            bus.addr <= {mem_addr_i[ADDR_W-1:LW], LW'(0)};
            bus.sel <= sel_c;
            bus.wdata <= wdata_c;
          end
        end
        REQ: if (bus.ack) begin
          state <= flush_i ? IDLE : DONE;
          result_o <= is_store(op_q) ? '0 : res_c;
        end else if (flush_i) begin
          state <= tmo ? IDLE : DRAIN;
          cnt <= '0;
        end else if (tmo) begin
          state <= DONE;
          excepttype_o <= Exc_Dbe;
        end
        DRAIN: if (bus.ack || tmo) state <= IDLE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench running a 32-bit and a 64-bit mem_lsu side by side against a byte-level reference model
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  localparam int T = 4;
  typedef struct { logic [31:0] res; logic [31:0] exc; int cyc; } res_t;
  typedef struct { logic [31:0] addr; logic [7:0] sel; logic [63:0] wdata; logic we; } bus_t;
  logic clk = 0, rst, valid_i, flush_i, stray;
  logic [6:0] op_type_i;
  logic [31:0] mem_addr_i, reg2_i, rd32;
  logic [63:0] rd64;
  logic st32, st64, v32, v64;
  logic [31:0] r32, r64, e32, e64;
  int cyc = 0, rc32 = 0, rc64 = 0, ack_at = 0, n_chk = 0, n_fail = 0;
  res_t q32[$], q64[$], e;
  bus_t qb32[$], qb64[$], cb32, cb64;
  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) b32();
  mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) b64();
  mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(T)) u32 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_type_i(op_type_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .flush_i(flush_i), .stall_o(st32), .result_valid_o(v32), .result_o(r32),
    .excepttype_o(e32), .bus(b32.master));
  mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(T)) u64 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_type_i(op_type_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .flush_i(flush_i), .stall_o(st64), .result_valid_o(v64), .result_o(r64),
    .excepttype_o(e64), .bus(b64.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rc32 <= b32.req ? rc32 + 1 : 0;
    rc64 <= b64.req ? rc64 + 1 : 0;
  end
  assign b32.ack = (b32.req && ack_at > 0 && rc32 == ack_at - 1) || stray;
  assign b64.ack = (b64.req && ack_at > 0 && rc64 == ack_at - 1) || stray;
  assign b32.rdata = rd32;
  assign b64.rdata = rd64;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic int size_of(input logic [6:0] op);
    case (op)
      Op_Lb, Op_Lbu, Op_Sb: return 1;
      Op_Lh, Op_Lhu, Op_Sh: return 2;
      Op_Lw, Op_Sw: return 4;
      default: return 0;
    endcase
  endfunction
  function automatic bit is_st(input logic [6:0] op);
    return op == Op_Sb || op == Op_Sh || op == Op_Sw;
  endfunction
  function automatic logic [7:0] sel_m(input int n, input logic [6:0] op, input logic [31:0] a);
    logic [7:0] s = '0;
    int k = int'(a[2:0]) % n;
    for (int b = 0; b < size_of(op); b++) s[n-1-(k+b)] = 1'b1;
    return s;
  endfunction
  function automatic logic [63:0] wd_m(input int n, input logic [6:0] op, input logic [31:0] r2);
    logic [63:0] w = '0;
    int sz = size_of(op);
    for (int j = 0; j < n; j++) w[8*(n-1-j) +: 8] = r2[8*(sz-1-(j % sz)) +: 8];
    return w;
  endfunction
  function automatic logic [31:0] ld_m(input int n, input logic [63:0] rd, input logic [6:0] op, input logic [31:0] a);
    logic [31:0] v = '0;
    int sz = size_of(op);
    int k = int'(a[2:0]) % n;
    for (int b = 0; b < sz; b++) v = {v[23:0], rd[8*(n-1-(k+b)) +: 8]};
    if ((op == Op_Lb || op == Op_Lh) && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    return v;
  endfunction

  task automatic chk_zero(input string t);
    chk({t, "_ctl32"}, {st32, v32, b32.req, b32.we, b32.sel}, 0);
    chk({t, "_ctl64"}, {st64, v64, b64.req, b64.we, b64.sel}, 0);
    chk({t, "_res"}, {r32, r64}, 0);
    chk({t, "_exc"}, {e32, e64}, 0);
    chk({t, "_addr"}, {b32.addr, b64.addr}, 0);
    chk({t, "_wdata32"}, b32.wdata, 0);
    chk({t, "_wdata64"}, b64.wdata, 0);
  endtask

  // Called half-way through an IDLE cycle: presents one op, queues what both units must do,
  // then steps the clock until both are IDLE again. f: flush in REQ cycle f; fd: flush in the
  // DONE cycle; rs: reset in REQ cycle rs; ack: REQ/DRAIN cycle that sees ack (0 = never).
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input int ack, input int f, input bit fd, input int rs);
    int c = cyc, sz = size_of(op), lat, busy = 0, nxt = cyc + 1, fc = 0;
    bit st = is_st(op), mis, ok;
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    ack_at = ack;
    valid_i = 1; op_type_i = op; mem_addr_i = a; reg2_i = r2;
    if (sz != 0 && mis) begin
      if (!fd) begin
        q32.push_back('{32'h0, st ? 32'h5 : 32'h4, c + 1});
        q64.push_back('{32'h0, st ? 32'h5 : 32'h4, c + 1});
      end
      fc = fd ? c + 1 : 0;
      nxt = c + 2;
    end else if (sz != 0) begin
      qb32.push_back('{a & ~32'd3, sel_m(4, op, a), wd_m(4, op, r2), st});
      qb64.push_back('{a & ~32'd7, sel_m(8, op, a), wd_m(8, op, r2), st});
      if (rs > 0) begin
        busy = rs;
        nxt = c + rs + 1;
      end else if (f > 0) begin
        fc = c + f;
        nxt = (ack == f) ? c + f + 1 : c + ((ack > 0 && ack <= f + T) ? ack : f + T) + 1;
        busy = nxt - c - 1;
      end else begin
        ok = ack > 0 && ack <= T;
        lat = (ok ? ack : T) + 1;
        busy = lat - 1;
        if (!fd) begin
          q32.push_back('{(ok && !st) ? ld_m(4, {32'h0, rd32}, op, a) : 32'h0, ok ? 32'h0 : 32'h7, c + lat});
          q64.push_back('{(ok && !st) ? ld_m(8, rd64, op, a) : 32'h0, ok ? 32'h0 : 32'h7, c + lat});
        end
        fc = fd ? c + lat : 0;
        nxt = c + lat + 1;
      end
    end
    #1;
    chk("accept_stall32", st32, sz != 0);
    chk("accept_stall64", st64, sz != 0);
    while (cyc < nxt) begin
      @(posedge clk);
      #1;
      valid_i = 0;
      flush_i = fc != 0 && cyc == fc;
      rst = rs > 0 && cyc == c + rs;
      #1;
      if (cyc < nxt) begin
        chk("busy_stall32", st32, cyc <= c + busy);
        chk("busy_stall64", st64, cyc <= c + busy);
      end
    end
  endtask

  always @(negedge clk) begin
    if (v32) begin
      chk("u32_result_expected", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("u32_result", r32, e.res);
        chk("u32_exc", e32, e.exc);
        chk("u32_latency", cyc, e.cyc);
      end
    end
    if (v64) begin
      chk("u64_result_expected", q64.size() != 0, 1);
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk("u64_result", r64, e.res);
        chk("u64_exc", e64, e.exc);
        chk("u64_latency", cyc, e.cyc);
      end
    end
    if (b32.req) begin
      if (rc32 == 0) begin
        chk("u32_bus_expected", qb32.size() != 0, 1);
        if (qb32.size() != 0) cb32 = qb32.pop_front();
      end
      chk("u32_bus_addr", b32.addr, cb32.addr);
      chk("u32_bus_sel", b32.sel, cb32.sel[3:0]);
      chk("u32_bus_wdata", b32.wdata, cb32.wdata[31:0]);
      chk("u32_bus_we", b32.we, cb32.we);
    end
    if (b64.req) begin
      if (rc64 == 0) begin
        chk("u64_bus_expected", qb64.size() != 0, 1);
        if (qb64.size() != 0) cb64 = qb64.pop_front();
      end
      chk("u64_bus_addr", b64.addr, cb64.addr);
      chk("u64_bus_sel", b64.sel, cb64.sel);
      chk("u64_bus_wdata", b64.wdata, cb64.wdata);
      chk("u64_bus_we", b64.we, cb64.we);
    end
  end

  initial begin
    logic [6:0] ops [9];
    ops = '{Op_Lb, Op_Lbu, Op_Lh, Op_Lhu, Op_Lw, Op_Sb, Op_Sh, Op_Sw, 7'h00};
    rst = 1; valid_i = 0; flush_i = 0; stray = 0; op_type_i = 0; mem_addr_i = 0; reg2_i = 0;
    rd32 = 0; rd64 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    rd32 = 32'h1122_33F0; rd64 = {$urandom, $urandom};
    issue(Op_Lb, 32'h1003, 32'h0, 4, 0, 0, 0);
    rd32 = $urandom;
    issue(Op_Sh, 32'h2006, 32'h0000_ABCD, 1, 0, 0, 0);
    issue(Op_Lw, 32'h3002, 32'h0, 1, 0, 0, 0);
    issue(Op_Sw, 32'h3001, 32'h55, 1, 0, 0, 0);
    issue(7'h00, 32'h1000, 32'h0, 1, 0, 0, 0);
    issue(Op_Lw, 32'h40, 32'h0, 0, 0, 0, 0);
    stray = 1;
    @(posedge clk);
    #1;
    stray = 0;
    @(posedge clk);
    #1;
    issue(Op_Lw, 32'h60, 32'h0, 4, 2, 0, 0);
    issue(Op_Lh, 32'h72, 32'h0, 2, 0, 1, 0);
    issue(Op_Lw, 32'h80, 32'h0, 0, 0, 0, 2);
    chk_zero("rst_mid");
    rd32 = 32'h8001_1234; rd64 = {32'h8001_1234, $urandom};
    issue(Op_Lhu, 32'h10, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      int ack, f;
      bit fd;
      rd32 = $urandom;
      rd64 = {$urandom, $urandom};
      f = ($urandom_range(0, 5) == 0) ? $urandom_range(1, T - 1) : 0;
      ack = f > 0 ? $urandom_range(f, f + T + 1) : $urandom_range(0, T + 1);
      fd = f == 0 && $urandom_range(0, 7) == 0;
      issue(ops[$urandom_range(0, 8)], 32'h1000 + $urandom_range(0, 15), $urandom, ack, f, fd, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("u32_results_pending", q32.size(), 0);
    chk("u64_results_pending", q64.size(), 0);
    chk("u32_bus_pending", qb32.size(), 0);
    chk("u64_bus_pending", qb64.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
